// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GCM widths, tag-length bounds and tag-checker FSM encoding
package gcm_pkg;
    localparam int NB_BLOCK    = 128;
    localparam int NB_BYTE     = 8;
    localparam int TAG_LEN_MIN = 12;
    localparam int TAG_LEN_MAX = 16;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BOTH,
        WAIT_RX,
        WAIT_CALC,
        REPORT
    } state_t;
endpackage

// File: rtl/gcm_rx_tag_checker_if.sv
// gcm_rx_tag_checker_if: frame/tag inputs, static config and verdict outputs of the rx tag checker
interface gcm_rx_tag_checker_if #(
    parameter int NB_BLOCK   = 128,
    parameter int NB_TAG_LEN = 5,
    parameter int NB_TIMER   = 16,
    parameter int NB_COUNT   = 32
);
    logic                  i_sop;
    logic [NB_BLOCK-1:0]   i_rx_tag;
    logic                  i_rx_tag_valid;
    logic [NB_BLOCK-1:0]   i_calc_tag;
    logic                  i_calc_tag_valid;
    logic [NB_TAG_LEN-1:0] i_rf_static_tag_len;
    logic [NB_TIMER-1:0]   i_rf_static_timeout;
    logic                  i_clear_counters;
    logic                  o_result_valid;
    logic                  o_tag_ok;
    logic                  o_tag_fail;
    logic                  o_timeout;
    logic                  o_abort;
    logic                  o_busy;
    logic [NB_COUNT-1:0]   o_fail_count;
    modport master (
        output i_sop, i_rx_tag, i_rx_tag_valid, i_calc_tag, i_calc_tag_valid,
               i_rf_static_tag_len, i_rf_static_timeout, i_clear_counters,
        input  o_result_valid, o_tag_ok, o_tag_fail, o_timeout, o_abort, o_busy, o_fail_count
    );
    modport slave (
        input  i_sop, i_rx_tag, i_rx_tag_valid, i_calc_tag, i_calc_tag_valid,
               i_rf_static_tag_len, i_rf_static_timeout, i_clear_counters,
        output o_result_valid, o_tag_ok, o_tag_fail, o_timeout, o_abort, o_busy, o_fail_count
    );
endinterface

// File: rtl/gcm_tag_mask_compare.sv
// gcm_tag_mask_compare: equality of the top tag-length bytes of two blocks
module gcm_tag_mask_compare #(
    parameter int NB_BLOCK   = 128,
    parameter int NB_TAG_LEN = 5
) (
    input  logic [NB_BLOCK-1:0]   i_a,
    input  logic [NB_BLOCK-1:0]   i_b,
    input  logic [NB_TAG_LEN-1:0] i_len,
    output logic                  o_equal
);
    import gcm_pkg::*;
    localparam int NB_BYTES = NB_BLOCK / NB_BYTE;
    int w_len;
    logic [NB_BYTES-1:0] w_diff;
    // illegal lengths fall back to a full-width compare
    assign w_len = (int'(i_len) < TAG_LEN_MIN || int'(i_len) > TAG_LEN_MAX) ? TAG_LEN_MAX : int'(i_len);
    for (genvar g = 0; g < NB_BYTES; g++) begin : g_byte
        assign w_diff[g] = (i_a[g*NB_BYTE +: NB_BYTE] != i_b[g*NB_BYTE +: NB_BYTE]) && (NB_BYTES - 1 - g < w_len);
    end
    assign o_equal = ~|w_diff;
endmodule

// File: rtl/gcm_rx_tag_checker.sv
// gcm_rx_tag_checker: captures rx/calc tags in any order and issues one pass/fail verdict per frame
module gcm_rx_tag_checker #(
    parameter int NB_BLOCK   = 128,
    parameter int NB_TAG_LEN = 5,
    parameter int NB_TIMER   = 16,
    parameter int NB_COUNT   = 32
) (
    input logic              i_clock,
    input logic              i_reset,
    gcm_rx_tag_checker_if.slave bus
);
    import gcm_pkg::*;
    state_t r_state, w_base, w_next;
    logic [NB_BLOCK-1:0] r_rx, r_calc, w_rx, w_calc;
    logic [NB_TIMER-1:0] r_timer;
    logic [NB_COUNT-1:0] r_count;
    logic r_valid, r_ok, r_fail, r_timeout, r_abort;
    logic w_wait, w_need_rx, w_need_calc, w_take_rx, w_take_calc, w_complete, w_timeout, w_equal;
    gcm_tag_mask_compare #(.NB_BLOCK(NB_BLOCK), .NB_TAG_LEN(NB_TAG_LEN)) u_cmp (
        .i_a(w_rx), .i_b(w_calc), .i_len(bus.i_rf_static_tag_len), .o_equal(w_equal)
    );
    // a sop restarts the frame, so same-cycle valids are judged as if already in WAIT_BOTH
    always_comb begin
        w_base      = bus.i_sop ? WAIT_BOTH : r_state;
        w_wait      = w_base == WAIT_BOTH || w_base == WAIT_RX || w_base == WAIT_CALC;
        w_need_rx   = w_base == WAIT_BOTH || w_base == WAIT_RX;
        w_need_calc = w_base == WAIT_BOTH || w_base == WAIT_CALC;
        w_take_rx   = w_need_rx && bus.i_rx_tag_valid;
        w_take_calc = w_need_calc && bus.i_calc_tag_valid;
        w_rx        = w_take_rx ? bus.i_rx_tag : (bus.i_sop ? '0 : r_rx);
        w_calc      = w_take_calc ? bus.i_calc_tag : (bus.i_sop ? '0 : r_calc);
        w_complete  = w_wait && (w_take_rx || !w_need_rx) && (w_take_calc || !w_need_calc);
        w_timeout   = w_wait && !bus.i_sop && !w_complete && bus.i_rf_static_timeout != '0 &&
                      r_timer == bus.i_rf_static_timeout;
        w_next      = w_base == REPORT ? IDLE :
                      (w_complete || w_timeout) ? REPORT :
                      w_take_rx ? WAIT_CALC :
                      w_take_calc ? WAIT_RX : w_base;
    end
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_rx      <= '0;
            r_calc    <= '0;
            r_timer   <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_ok      <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_rx      <= w_rx;
            r_calc    <= w_calc;
            r_timer   <= (!bus.i_sop && w_wait) ? r_timer + 1'b1 : '0;
            r_valid   <= w_next == REPORT;
            r_ok      <= w_complete && w_equal;
            r_fail    <= w_next == REPORT && !(w_complete && w_equal);
            r_timeout <= w_timeout;
            r_abort   <= bus.i_sop && (r_state == WAIT_BOTH || r_state == WAIT_RX || r_state == WAIT_CALC);
            if (r_valid && r_fail)
                r_count <= bus.i_clear_counters ? NB_COUNT'(1) : r_count + {{(NB_COUNT-1){1'b0}}, ~&r_count};
            else if (bus.i_clear_counters)
                r_count <= '0;
        end
    end
    assign bus.o_result_valid = r_valid;
    assign bus.o_tag_ok       = r_ok;
    assign bus.o_tag_fail     = r_fail;
    assign bus.o_timeout      = r_timeout;
    assign bus.o_abort        = r_abort;
    assign bus.o_busy         = r_state != IDLE;
    assign bus.o_fail_count   = r_count;
endmodule

// File: tb/tb_gcm_rx_tag_checker.sv
// tb_gcm_rx_tag_checker: table-driven vectors plus hand sequences for timeout, abort, saturation and reset
module tb_gcm_rx_tag_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gcm_rx_tag_checker_if #(.NB_BLOCK(128), .NB_TAG_LEN(5), .NB_TIMER(16), .NB_COUNT(4)) bus ();
    gcm_rx_tag_checker #(.NB_BLOCK(128), .NB_TAG_LEN(5), .NB_TIMER(16), .NB_COUNT(4)) dut (
        .i_clock(clk), .i_reset(rst), .bus(bus.slave)
    );

    localparam logic [127:0] T  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] T2 = 128'h0123456789ABCDEF0123456789ABCDEE;
    // output vector order: {valid, ok, fail, timeout, abort, busy}
    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] B   = 6'b000001;
    localparam logic [5:0] OKR = 6'b110001;
    localparam logic [5:0] FR  = 6'b101001;
    localparam logic [5:0] TOR = 6'b101101;
    localparam logic [5:0] AB  = 6'b000011;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         sop;
        logic         rxv;
        logic [127:0] rx;
        logic         cv;
        logic [127:0] calc;
        logic [4:0]   len;
        logic [5:0]   exp_o;
        logic [3:0]   exp_cnt;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic sop, logic rxv, logic [127:0] rx, logic cv, logic [127:0] calc,
                                logic [4:0] len, logic [5:0] exp_o, logic [3:0] exp_cnt);
        vec_t v;
        v.sop = sop; v.rxv = rxv; v.rx = rx; v.cv = cv; v.calc = calc;
        v.len = len; v.exp_o = exp_o; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    function automatic logic [5:0] outs();
        return {bus.o_result_valid, bus.o_tag_ok, bus.o_tag_fail, bus.o_timeout, bus.o_abort, bus.o_busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic sop, input logic rxv, input logic [127:0] rx,
                         input logic cv, input logic [127:0] calc);
        bus.i_sop = sop; bus.i_rx_tag_valid = rxv; bus.i_rx_tag = rx;
        bus.i_calc_tag_valid = cv; bus.i_calc_tag = calc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, '0, 0, '0);
        bus.i_rf_static_tag_len = 5'd16;
        bus.i_rf_static_timeout = '0;
        bus.i_clear_counters    = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_outs", 32'(outs()), 32'(Z));
        chk("reset_count", 32'(bus.o_fail_count), 0);
        repeat (2) tick();
        rst = 1'b0;

        tbl.push_back(mk(1, 0, '0, 0, '0, 16, B, 0));
        tbl.push_back(mk(0, 1, T, 1, T, 16, OKR, 0));
        tbl.push_back(mk(0, 0, '0, 0, '0, 16, Z, 0));
        tbl.push_back(mk(1, 0, '0, 0, '0, 12, B, 0));
        tbl.push_back(mk(0, 0, '0, 1, T, 12, B, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, '0, 0, '0, 12, B, 0));
        tbl.push_back(mk(0, 1, T2, 0, '0, 12, OKR, 0));
        tbl.push_back(mk(0, 0, '0, 0, '0, 12, Z, 0));
        tbl.push_back(mk(1, 0, '0, 0, '0, 16, B, 0));
        tbl.push_back(mk(0, 0, '0, 1, T, 16, B, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, '0, 0, '0, 16, B, 0));
        tbl.push_back(mk(0, 1, T2, 0, '0, 16, FR, 0));
        tbl.push_back(mk(0, 0, '0, 0, '0, 16, Z, 1));
        tbl.push_back(mk(1, 1, T, 1, T, 16, OKR, 1));
        tbl.push_back(mk(0, 0, '0, 0, '0, 16, Z, 1));
        tbl.push_back(mk(1, 0, '0, 0, '0, 16, B, 1));
        tbl.push_back(mk(0, 1, T, 0, '0, 16, B, 1));
        tbl.push_back(mk(0, 1, T2, 0, '0, 16, B, 1));
        tbl.push_back(mk(0, 0, '0, 1, T, 16, OKR, 1));
        tbl.push_back(mk(0, 0, '0, 0, '0, 16, Z, 1));
        foreach (tbl[i]) begin
            drive(tbl[i].sop, tbl[i].rxv, tbl[i].rx, tbl[i].cv, tbl[i].calc);
            bus.i_rf_static_tag_len = tbl[i].len;
            tick();
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(tbl[i].exp_o));
            chk($sformatf("vec%0d_count", i), 32'(bus.o_fail_count), 32'(tbl[i].exp_cnt));
        end

        // timeout: only rx tag arrives, verdict 11 cycles after sop
        bus.i_rf_static_timeout = 16'd10;
        drive(1, 0, '0, 0, '0);
        tick();
        drive(0, 1, T, 0, '0);
        tick();
        drive(0, 0, '0, 0, '0);
        for (int i = 2; i <= 10; i++) begin
            tick();
            chk($sformatf("to_wait%0d", i), 32'(outs()), 32'(B));
        end
        tick();
        chk("to_verdict", 32'(outs()), 32'(TOR));
        drive(0, 0, '0, 1, T);
        tick();
        chk("to_idle", 32'(outs()), 32'(Z));
        chk("to_count", 32'(bus.o_fail_count), 2);
        tick();
        chk("to_late_calc", 32'(outs()), 32'(Z));
        bus.i_rf_static_timeout = '0;

        // abort: new sop while waiting for calc tag
        drive(1, 0, '0, 0, '0);
        tick();
        drive(0, 1, T2, 0, '0);
        tick();
        drive(1, 0, '0, 0, '0);
        tick();
        chk("abort_pulse", 32'(outs()), 32'(AB));
        drive(0, 0, '0, 0, '0);
        tick();
        chk("abort_after", 32'(outs()), 32'(B));
        drive(0, 1, T, 1, T);
        tick();
        chk("abort_next_ok", 32'(outs()), 32'(OKR));
        drive(0, 0, '0, 0, '0);
        tick();
        chk("abort_idle", 32'(outs()), 32'(Z));
        chk("abort_count", 32'(bus.o_fail_count), 2);

        // saturation: 15 more fails on a 4-bit counter
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, T, 1, T2);
            tick();
            drive(0, 0, '0, 0, '0);
            tick();
        end
        chk("sat_count", 32'(bus.o_fail_count), 15);
        drive(1, 1, T, 1, T2);
        tick();
        chk("clr_fail_verdict", 32'(outs()), 32'(FR));
        drive(0, 0, '0, 0, '0);
        bus.i_clear_counters = 1'b1;
        tick();
        chk("clr_with_fail", 32'(bus.o_fail_count), 1);
        tick();
        chk("clr_alone", 32'(bus.o_fail_count), 0);
        bus.i_clear_counters = 1'b0;

        // reset while in WAIT_CALC
        drive(1, 0, '0, 0, '0);
        tick();
        drive(0, 1, T, 0, '0);
        tick();
        chk("rst_pre_busy", 32'(outs()), 32'(B));
        drive(0, 0, '0, 1, T);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_outs", 32'(outs()), 32'(Z));
        chk("rst_mid_count", 32'(bus.o_fail_count), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_after%0d", i), 32'(outs()), 32'(Z));
        end
        drive(0, 0, '0, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
